// File: rtl/ad9959_serial_engine.sv
`default_nettype none
// ============================================================================
// Module   : ad9959_serial_engine
// Purpose  : Serial write engine between the AD9959 register bank and the
//            DDS pins. Accepts one write command (instruction address plus
//            1-4 data bytes). It shifts the instruction byte and then the data
//            bytes MSB first on SDIO_0, framed by CS_N/SCLK in 3-wire
//            single-bit mode. It can then strobe IO_UPDATE.
// Ports    : ACLK, ARESET          - clock, synchronous active-high reset
//            cmd_valid/cmd_ready   - command handshake (ready only in IDLE)
//            cmd_addr/len/data     - register address, byte count, data
//            cmd_update            - pulse IO_UPDATE after the frame
//            busy, done, err_len   - status
//            dds_cs_n, dds_sclk,
//            dds_sdio0,
//            dds_io_update         - DDS pins
// Revision : 1.0 - initial release
// ============================================================================
module ad9959_serial_engine #(
    parameter int CLK_DIV     = 4,
    parameter int IOUPD_WIDTH = 4
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_addr,
    input  logic [2:0]  cmd_len,
    input  logic [31:0] cmd_data,
    input  logic        cmd_update,
    output logic        busy,
    output logic        done,
    output logic        err_len,
    output logic        dds_cs_n,
    output logic        dds_sclk,
    output logic        dds_sdio0,
    output logic        dds_io_update
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);
    localparam logic [7:0] c_upd_last = 8'(IOUPD_WIDTH - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [7:0]  r_div;
    logic        r_phase;      // 0 = SCLK low phase, 1 = SCLK high phase
    logic [5:0]  r_bit;
    logic [5:0]  r_bit_last;
    logic [39:0] r_shift;      // frame left-justified; bit 39 drives SDIO_0
    logic        r_update;
    logic        r_err_len;

    logic        w_accept;
    logic        w_len_ok;
    logic        w_div_end;
    logic        w_upd_end;
    logic        w_last_bit;

    assign w_accept   = cmd_valid && (r_state == S_IDLE);
    assign w_len_ok   = (cmd_len != 3'd0) && (cmd_len <= 3'd4);
    assign w_div_end  = (r_div == c_div_last);
    assign w_upd_end  = (r_div == c_upd_last);
    assign w_last_bit = (r_bit == r_bit_last);

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && w_len_ok) w_next = S_SETUP;
            S_SETUP:  if (w_div_end) w_next = S_SHIFT;
            S_SHIFT:  if (w_div_end && r_phase && w_last_bit) w_next = S_HOLD;
            S_HOLD:   if (w_div_end) w_next = r_update ? S_UPDATE : S_DONE;
            S_UPDATE: if (w_upd_end) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath: phase divider, bit counter, shift register, command capture
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_div      <= 8'd0;
            r_phase    <= 1'b0;
            r_bit      <= 6'd0;
            r_bit_last <= 6'd0;
            r_shift    <= 40'd0;
            r_update   <= 1'b0;
            r_err_len  <= 1'b0;
        end else begin
            // An illegal length is consumed in IDLE and only flagged
            r_err_len <= w_accept && !w_len_ok;

            // The divider restarts on every state change and on each SCLK phase
            if ((r_state == S_IDLE) || (w_next != r_state) ||
                ((r_state == S_SHIFT) && w_div_end)) begin
                r_div <= 8'd0;
            end else begin
                r_div <= r_div + 8'd1;
            end

            if (w_accept && w_len_ok) begin
                r_phase  <= 1'b0;
                r_bit    <= 6'd0;
                r_update <= cmd_update;
                case (cmd_len)
                    3'd1: begin
                        r_shift    <= {3'b000, cmd_addr, cmd_data[7:0], 24'd0};
                        r_bit_last <= 6'd15;
                    end
                    3'd2: begin
                        r_shift    <= {3'b000, cmd_addr, cmd_data[15:0], 16'd0};
                        r_bit_last <= 6'd23;
                    end
                    3'd3: begin
                        r_shift    <= {3'b000, cmd_addr, cmd_data[23:0], 8'd0};
                        r_bit_last <= 6'd31;
                    end
                    default: begin
                        r_shift    <= {3'b000, cmd_addr, cmd_data};
                        r_bit_last <= 6'd39;
                    end
                endcase
            end else if ((r_state == S_SHIFT) && w_div_end) begin
                r_phase <= ~r_phase;
                if (r_phase) begin
                    r_bit <= r_bit + 6'd1;
                    // Advance data on the falling SCLK edge; the last bit is
                    // kept through HOLD so SDIO_0 only drops when CS_N rises.
                    if (!w_last_bit) begin
                        r_shift <= {r_shift[38:0], 1'b0};
                    end
                end
            end
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        cmd_ready     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        dds_cs_n      = 1'b1;
        dds_sclk      = 1'b0;
        dds_sdio0     = 1'b0;
        dds_io_update = 1'b0;
        case (r_state)
            S_IDLE: cmd_ready = 1'b1;
            S_SETUP: begin
                busy      = 1'b1;
                dds_cs_n  = 1'b0;
                dds_sdio0 = r_shift[39];
            end
            S_SHIFT: begin
                busy      = 1'b1;
                dds_cs_n  = 1'b0;
                dds_sclk  = r_phase;
                dds_sdio0 = r_shift[39];
            end
            S_HOLD: begin
                busy      = 1'b1;
                dds_cs_n  = 1'b0;
                dds_sdio0 = r_shift[39];
            end
            S_UPDATE: begin
                busy          = 1'b1;
                dds_io_update = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    assign err_len = r_err_len;

endmodule
`default_nettype wire

// File: tb/tb_ad9959_serial_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad9959_serial_engine
// Purpose  : Directed self-checking bench for ad9959_serial_engine. The
//            expected frame, timing and strobe counts are queued at command
//            issue and retired when the DUT raises done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad9959_serial_engine;

    localparam int D = 4;
    localparam int U = 4;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_addr;
    logic [2:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        cmd_update;
    logic        busy;
    logic        done;
    logic        err_len;
    logic        dds_cs_n;
    logic        dds_sclk;
    logic        dds_sdio0;
    logic        dds_io_update;

    ad9959_serial_engine #(
        .CLK_DIV     (D),
        .IOUPD_WIDTH (U)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_data      (cmd_data),
        .cmd_update    (cmd_update),
        .busy          (busy),
        .done          (done),
        .err_len       (err_len),
        .dds_cs_n      (dds_cs_n),
        .dds_sclk      (dds_sclk),
        .dds_sdio0     (dds_sdio0),
        .dds_io_update (dds_io_update)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [39:0] frame;
        int          nbits;
        int          lat;
        int          cs_low;
        int          io;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [4:0] a, input logic [2:0] l,
                            input logic [31:0] d, input logic u);
        exp_t        e;
        int          n;
        logic [39:0] f;
        logic [39:0] mask;
        n    = 8 + 8 * int'(l);
        mask = (40'd1 << (8 * int'(l))) - 40'd1;
        f    = (40'(a) << (8 * int'(l))) | (40'(d) & mask);
        e.frame  = f;
        e.nbits  = n;
        e.cs_low = D * (2 * n + 2);
        e.io     = u ? U : 0;
        e.lat    = e.cs_low + e.io + 1;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [4:0] a, input logic [2:0] l,
                         input logic [31:0] d, input logic u);
        cmd_valid  = 1'b1;
        cmd_addr   = a;
        cmd_len    = l;
        cmd_data   = d;
        cmd_update = u;
    endtask

    // Complete the acceptance edge, then scramble the fields (don't-care now)
    task automatic accept();
        @(posedge ACLK);
        #1;
        cmd_valid  = 1'b0;
        cmd_addr   = 5'($urandom);
        cmd_len    = 3'($urandom);
        cmd_data   = $urandom;
        cmd_update = 1'($urandom);
    endtask

    // Called just after an acceptance edge; returns in the done cycle
    task automatic observe(input string tag);
        exp_t        e;
        int          k;
        int          rises;
        int          cs_low;
        int          io;
        int          viol;
        logic [39:0] cap;
        logic        psclk;
        logic        psdio;
        bit          got;
        k = 0; rises = 0; cs_low = 0; io = 0; viol = 0;
        cap = 40'd0; psclk = 1'b0; psdio = 1'b0; got = 1'b0;
        while (!got && k < 3000) begin
            @(negedge ACLK);
            k++;
            if (dds_sclk && !psclk) begin
                cap = {cap[38:0], dds_sdio0};
                rises++;
            end
            if (dds_sclk && (dds_sdio0 !== psdio)) viol++;
            if (!dds_cs_n) cs_low++;
            if (dds_io_update) begin
                io++;
                if (!dds_cs_n) viol++;
            end
            if (done) got = 1'b1;
            psclk = dds_sclk;
            psdio = dds_sdio0;
        end
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_latency"}, 64'(k), 64'(e.lat));
            chk({tag, "_frame"}, 64'(cap), 64'(e.frame));
            chk({tag, "_sclk_rises"}, 64'(rises), 64'(e.nbits));
            chk({tag, "_cs_low_cycles"}, 64'(cs_low), 64'(e.cs_low));
            chk({tag, "_io_update_cycles"}, 64'(io), 64'(e.io));
        end
        chk({tag, "_sdio_violations"}, 64'(viol), 64'd0);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int   rises;
        int   k;
        int   dones;
        logic psclk;

        // Reset with a command presented simultaneously: reset must win
        ARESET = 1'b1;
        drive(5'h01, 3'd1, 32'hAA, 1'b0);
        repeat (3) @(negedge ACLK);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err_len", 64'(err_len), 64'd0);
        chk("rst_cs_n", 64'(dds_cs_n), 64'd1);
        chk("rst_sclk", 64'(dds_sclk), 64'd0);
        chk("rst_sdio0", 64'(dds_sdio0), 64'd0);
        chk("rst_io_update", 64'(dds_io_update), 64'd0);
        ARESET    = 1'b0;
        cmd_valid = 1'b0;
        @(negedge ACLK);
        chk("post_rst_idle_cs_n", 64'(dds_cs_n), 64'd1);

        // Single byte, no update
        @(negedge ACLK);
        drive(5'h00, 3'd1, 32'h0000_00F0, 1'b0);
        push_exp(5'h00, 3'd1, 32'h0000_00F0, 1'b0);
        accept();
        observe("t1");

        // Same frame with IO_UPDATE
        @(negedge ACLK);
        drive(5'h00, 3'd1, 32'h0000_00F0, 1'b1);
        push_exp(5'h00, 3'd1, 32'h0000_00F0, 1'b1);
        accept();
        observe("t2");

        // Full 4-byte CFTW0 write
        @(negedge ACLK);
        drive(5'h04, 3'd4, 32'h1234_5678, 1'b0);
        push_exp(5'h04, 3'd4, 32'h1234_5678, 1'b0);
        accept();
        observe("t3");

        // Illegal lengths 0 and 5
        @(negedge ACLK);
        drive(5'h03, 3'd0, 32'h55, 1'b1);
        accept();
        @(negedge ACLK);
        chk("len0_err_len", 64'(err_len), 64'd1);
        chk("len0_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("len0_cs_n", 64'(dds_cs_n), 64'd1);
        chk("len0_sclk", 64'(dds_sclk), 64'd0);
        @(negedge ACLK);
        chk("len0_err_len_clear", 64'(err_len), 64'd0);
        drive(5'h03, 3'd5, 32'h55, 1'b1);
        accept();
        @(negedge ACLK);
        chk("len5_err_len", 64'(err_len), 64'd1);
        chk("len5_cs_n", 64'(dds_cs_n), 64'd1);
        chk("len5_busy", 64'(busy), 64'd0);
        @(negedge ACLK);
        chk("len5_err_len_clear", 64'(err_len), 64'd0);
        chk("len5_sclk", 64'(dds_sclk), 64'd0);
        chk("len5_cmd_ready", 64'(cmd_ready), 64'd1);

        // Reset on the 10th SCLK rising edge of a 2-byte write
        @(negedge ACLK);
        drive(5'h02, 3'd2, 32'h0000_A55A, 1'b1);
        push_exp(5'h02, 3'd2, 32'h0000_A55A, 1'b1);
        accept();
        rises = 0; k = 0; dones = 0; psclk = 1'b0;
        while (rises < 10 && k < 2000) begin
            @(negedge ACLK);
            k++;
            if (dds_sclk && !psclk) rises++;
            if (done) dones++;
            psclk = dds_sclk;
        end
        chk("abort_reached_rise10", 64'(rises), 64'd10);
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("abort_cs_n", 64'(dds_cs_n), 64'd1);
        chk("abort_sclk", 64'(dds_sclk), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("abort_io_update", 64'(dds_io_update), 64'd0);
        if (done) dones++;
        ARESET = 1'b0;
        void'(sb.pop_front());
        repeat (3) begin
            @(negedge ACLK);
            if (done) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);

        // Normal command after the abort
        drive(5'h0A, 3'd3, 32'h00AB_CDEF, 1'b1);
        push_exp(5'h0A, 3'd3, 32'h00AB_CDEF, 1'b1);
        accept();
        observe("t_after_abort");

        // Back-to-back with cmd_valid held high
        @(negedge ACLK);
        drive(5'h01, 3'd2, 32'h0000_BEEF, 1'b0);
        push_exp(5'h01, 3'd2, 32'h0000_BEEF, 1'b0);
        @(posedge ACLK);
        #1;
        drive(5'h12, 3'd1, 32'h0000_005A, 1'b1);
        push_exp(5'h12, 3'd1, 32'h0000_005A, 1'b1);
        observe("b2b_a");
        chk("b2b_ready_in_done", 64'(cmd_ready), 64'd0);
        chk("b2b_cs_n_in_done", 64'(dds_cs_n), 64'd1);
        @(negedge ACLK);
        chk("b2b_ready_after_done", 64'(cmd_ready), 64'd1);
        chk("b2b_cs_n_gap", 64'(dds_cs_n), 64'd1);
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b0;
        observe("b2b_b");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
